aq_spsram_pwr_wrap: RTL and testbench



---
 rtl/aq_spsram_pkg.sv | 16 +
 rtl/aq_spsram_array.sv | 32 +++
 rtl/aq_spsram_pwr_wrap.sv | 180 ++++++++++++++++++
 tb/tb_aq_spsram_pwr_wrap.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/aq_spsram_pkg.sv
// Shared types and helpers for the power-managed single-port SRAM wrapper.
package aq_spsram_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    // The wake counter runs 0..cyc-1, so it needs clog2(cyc) bits, never fewer than one.
    function automatic int wake_cnt_w(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/aq_spsram_array.sv
// Behavioural single-port storage with per-bit write mask and registered read.
// Replace this module with a foundry macro wrapper when targeting silicon.
module aq_spsram_array #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 98,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wmask_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // No reset: contents and the read register only change on explicit accesses.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= (mem[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end
        if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/aq_spsram_pwr_wrap.sv
// SRAM wrapper with post-reset zero fill, optional output register and a
// sleep/wake power FSM; controllers must only access while READY is high.
module aq_spsram_pwr_wrap
    import aq_spsram_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 98,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int OUT_REG    = 0,
    parameter int INIT_EN    = 1,
    parameter int WAKE_CYC   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  SLEEP_REQ,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  Q_VLD,
    output logic                  READY,
    output logic                  INIT_DONE,
    output logic                  DROP
);

    localparam int                    WCW        = wake_cnt_w(WAKE_CYC);
    localparam logic [ADDR_WIDTH:0]   DEPTH_X    = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [WCW-1:0]        WAKE_LAST  = WCW'(WAKE_CYC - 1);
    localparam state_t                RST_STATE  = (INIT_EN != 0) ? ST_INIT : ST_IDLE;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [WCW-1:0]        wake_cnt_q, wake_cnt_d;
    logic                  ready_q, ready_d;
    logic                  init_done_q, init_done_d;
    logic                  drop_q, drop_d;
    logic                  rd_vld_q, rd_vld_d;

    logic                  in_range;
    logic                  acc;
    logic                  rej;
    logic                  pipe_busy;

    logic                  arr_we;
    logic                  arr_re;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_wmask;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;

    // Out-of-range addresses are rejected exactly like accesses while not ready.
    assign in_range = ({1'b0, A} < DEPTH_X);
    assign acc      = !CEN && ready_q && in_range;
    assign rej      = !CEN && !(ready_q && in_range);

    assign arr_we    = (state_q == ST_INIT) || (acc && GWEN);
    assign arr_re    = acc && !GWEN;
    assign arr_addr  = (state_q == ST_INIT) ? init_cnt_q : A;
    assign arr_wmask = (state_q == ST_INIT) ? '1 : WEN;
    assign arr_wdata = (state_q == ST_INIT) ? '0 : D;

    aq_spsram_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (arr_addr),
        .wmask_i (arr_wmask),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                // A pending access holds off sleep; it is re-evaluated next cycle.
                if (SLEEP_REQ && CEN && !pipe_busy) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (!SLEEP_REQ) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    wake_cnt_d = wake_cnt_q + WCW'(1);
                end
            end
            default: state_d = RST_STATE;
        endcase
        ready_d     = (state_d == ST_IDLE);
        init_done_d = init_done_q || (state_d != ST_INIT);
        drop_d      = rej;
        rd_vld_d    = arr_re;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= RST_STATE;
            init_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            drop_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            drop_q      <= drop_d;
            rd_vld_q    <= rd_vld_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q_q;
            logic                  q_vld_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    q_q     <= '0;
                    q_vld_q <= 1'b0;
                end else begin
                    q_vld_q <= rd_vld_q;
                    if (rd_vld_q) begin
                        q_q <= arr_rdata;
                    end
                end
            end

            assign Q         = q_q;
            assign Q_VLD     = q_vld_q;
            assign pipe_busy = rd_vld_q;
        end else begin : g_out_direct
            // The array read register has no reset, so mask it until the first read lands.
            logic seen_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    seen_q <= 1'b0;
                end else if (arr_re) begin
                    seen_q <= 1'b1;
                end
            end

            assign Q         = seen_q ? arr_rdata : '0;
            assign Q_VLD     = rd_vld_q;
            assign pipe_busy = 1'b0;
        end
    endgenerate

    assign READY     = ready_q;
    assign INIT_DONE = init_done_q;
    assign DROP      = drop_q;

endmodule

// File: tb/tb_aq_spsram_pwr_wrap.sv
// Directed bench: one 64-deep unregistered-output instance and one 48-deep
// registered-output instance, driven from a single linear stimulus sequence.
module tb_aq_spsram_pwr_wrap;

    localparam int DW = 98;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [5:0]    a0, a1;
    logic          cen0, cen1, gwen0, gwen1, slp0, slp1;
    logic [DW-1:0] wen0, wen1, d0, d1, q0, q1;
    logic          qv0, qv1, rdy0, rdy1, idn0, idn1, drp0, drp1;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_mask;
    logic [DW-1:0] pat;
    logic [DW-1:0] pp [3];

    aq_spsram_pwr_wrap #(
        .DEPTH(64), .DATA_WIDTH(DW), .OUT_REG(0), .INIT_EN(1), .WAKE_CYC(4)
    ) u_dut0 (
        .CLK(clk), .RST(rst), .A(a0), .CEN(cen0), .GWEN(gwen0), .WEN(wen0), .D(d0),
        .SLEEP_REQ(slp0), .Q(q0), .Q_VLD(qv0), .READY(rdy0), .INIT_DONE(idn0), .DROP(drp0)
    );

    aq_spsram_pwr_wrap #(
        .DEPTH(48), .DATA_WIDTH(DW), .OUT_REG(1), .INIT_EN(1), .WAKE_CYC(4)
    ) u_dut1 (
        .CLK(clk), .RST(rst), .A(a1), .CEN(cen1), .GWEN(gwen1), .WEN(wen1), .D(d1),
        .SLEEP_REQ(slp1), .Q(q1), .Q_VLD(qv1), .READY(rdy1), .INIT_DONE(idn1), .DROP(drp1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_mask = {{(DW-8){1'b1}}, 8'h00};
        pat      = {34'h2_DEAD_BEEF, 64'h0123_4567_89AB_CDEF};
        pp[0]    = {DW{1'b1}} ^ DW'(1);
        pp[1]    = DW'(64'h1111_2222_3333_4444) << 3;
        pp[2]    = {(DW/2){2'b10}};

        rst = 1'b1;
        a0 = '0; cen0 = 1'b1; gwen0 = 1'b0; wen0 = '0; d0 = '0; slp0 = 1'b0;
        a1 = '0; cen1 = 1'b1; gwen1 = 1'b0; wen1 = '0; d1 = '0; slp1 = 1'b0;
        repeat (2) tick();

        // Reset values
        chk("rst_q",     128'(q0),   128'(0));
        chk("rst_qvld",  128'(qv0),  128'(0));
        chk("rst_ready", 128'(rdy0), 128'(0));
        chk("rst_idone", 128'(idn0), 128'(0));
        chk("rst_drop",  128'(drp0), 128'(0));
        chk("rst_ready1",128'(rdy1), 128'(0));

        // Reset in the middle of the fill
        rst = 1'b0;
        repeat (20) tick();
        chk("midinit_ready", 128'(rdy0), 128'(0));
        rst = 1'b1;
        #1;
        chk("midinit_rst_ready", 128'(rdy0), 128'(0));
        chk("midinit_rst_idone", 128'(idn0), 128'(0));
        chk("midinit_rst_q",     128'(q0),   128'(0));
        tick();
        rst = 1'b0;

        // Full fill must take DEPTH cycles after release
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 47) chk("init1_ready_before", 128'(rdy1), 128'(0));
            if (i == 48) begin
                chk("init1_ready_after", 128'(rdy1), 128'(1));
                chk("init1_idone",       128'(idn1), 128'(1));
            end
            if (i == 63) begin
                chk("init0_ready_before", 128'(rdy0), 128'(0));
                chk("init0_idone_before", 128'(idn0), 128'(0));
            end
            if (i == 64) begin
                chk("init0_ready_after", 128'(rdy0), 128'(1));
                chk("init0_idone_after", 128'(idn0), 128'(1));
            end
        end

        // Every word reads back as zero, one read per cycle
        for (int i = 0; i < 64; i++) begin
            a0 = 6'(i); cen0 = 1'b0; gwen0 = 1'b0;
            tick();
            chk("init_read", 128'({qv0, q0}), 128'({1'b1, {DW{1'b0}}}));
        end
        cen0 = 1'b1;

        // Masked write, latency 1
        a0 = 6'd5; cen0 = 1'b0; gwen0 = 1'b1; wen0 = '1; d0 = '1;
        tick();
        chk("mw_wr1_qvld", 128'(qv0), 128'(0));
        d0 = '0; wen0 = DW'(8'hFF);
        tick();
        chk("mw_wr2_qvld", 128'(qv0), 128'(0));
        chk("mw_wr2_qhold", 128'(q0), 128'(0));
        gwen0 = 1'b0;
        tick();
        chk("mw_rd_qvld", 128'(qv0), 128'(1));
        chk("mw_rd_q",    128'(q0),  128'(exp_mask));
        cen0 = 1'b1;
        tick();
        chk("mw_idle_qvld", 128'(qv0), 128'(0));
        chk("mw_idle_qhold", 128'(q0), 128'(exp_mask));

        // Sleep: access in the same cycle as the request wins
        a0 = 6'd7; cen0 = 1'b0; gwen0 = 1'b1; wen0 = '1; d0 = pat;
        tick();
        gwen0 = 1'b0; slp0 = 1'b1;
        tick();
        chk("slp_acc_qvld",  128'(qv0),  128'(1));
        chk("slp_acc_q",     128'(q0),   128'(pat));
        chk("slp_acc_ready", 128'(rdy0), 128'(1));
        cen0 = 1'b1;
        tick();
        chk("slp_enter_ready", 128'(rdy0), 128'(0));
        cen0 = 1'b0; gwen0 = 1'b1; d0 = '0;
        tick();
        chk("slp_drop", 128'(drp0), 128'(1));
        cen0 = 1'b1; gwen0 = 1'b0;
        tick();
        chk("slp_drop_clear", 128'(drp0), 128'(0));
        chk("slp_still_asleep", 128'(rdy0), 128'(0));
        slp0 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) chk("wake_ready_before", 128'(rdy0), 128'(0));
            if (i == 5) chk("wake_ready_after",  128'(rdy0), 128'(1));
        end
        a0 = 6'd7; cen0 = 1'b0; gwen0 = 1'b0;
        tick();
        chk("wake_data_qvld", 128'(qv0), 128'(1));
        chk("wake_data_q",    128'(q0),  128'(pat));
        cen0 = 1'b1;

        // Pipeline: three consecutive reads on the registered-output instance
        for (int k = 0; k < 3; k++) begin
            a1 = 6'(k + 1); cen1 = 1'b0; gwen1 = 1'b1; wen1 = '1; d1 = pp[k];
            tick();
        end
        gwen1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 3) begin
                a1 = 6'(k); cen1 = 1'b0;
            end else begin
                cen1 = 1'b1;
            end
            tick();
            if (k == 1) chk("pipe_lat_qvld", 128'(qv1), 128'(0));
            if (k >= 2 && k <= 4) begin
                chk("pipe_qvld", 128'(qv1), 128'(1));
                chk("pipe_q",    128'(q1),  128'(pp[k-2]));
            end
            if (k == 5) begin
                chk("pipe_end_qvld", 128'(qv1), 128'(0));
                chk("pipe_end_qhold", 128'(q1), 128'(pp[2]));
            end
        end

        // Out-of-range address on the 48-deep instance
        a1 = 6'd50; cen1 = 1'b0; gwen1 = 1'b0;
        tick();
        chk("range_drop", 128'(drp1), 128'(1));
        chk("range_qvld", 128'(qv1),  128'(0));
        cen1 = 1'b1;
        tick();
        chk("range_drop_clear", 128'(drp1), 128'(0));
        chk("range_qvld2",      128'(qv1),  128'(0));
        chk("range_qhold",      128'(q1),   128'(pp[2]));

        // Masked write, latency 2
        a1 = 6'd5; cen1 = 1'b0; gwen1 = 1'b1; wen1 = '1; d1 = '1;
        tick();
        d1 = '0; wen1 = DW'(8'hFF);
        tick();
        gwen1 = 1'b0;
        tick();
        chk("mw1_lat_qvld", 128'(qv1), 128'(0));
        cen1 = 1'b1;
        tick();
        chk("mw1_qvld", 128'(qv1), 128'(1));
        chk("mw1_q",    128'(q1),  128'(exp_mask));

        // Reset discards a read still in the output stage
        a1 = 6'd2; cen1 = 1'b0; gwen1 = 1'b0;
        tick();
        cen1 = 1'b1;
        rst = 1'b1;
        #1;
        chk("rstflight_qvld",  128'(qv1),  128'(0));
        chk("rstflight_q",     128'(q1),   128'(0));
        chk("rstflight_ready", 128'(rdy1), 128'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("rstflight_qvld_after", 128'(qv1),  128'(0));
        chk("rstflight_q0",         128'(q0),   128'(0));
        chk("rstflight_idone0",     128'(idn0), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
